// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared encodings and defaults for the fifo block and its read-side engines
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 32;
    localparam int HDR_LEN_W       = 8;
    localparam int HDR_LEN_LSB     = 0;
    localparam int STAT_CNT_W      = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/fifo.sv
// rtl/fifo.sv - show-ahead synchronous FIFO; head word is visible on rd_data_o whenever not empty
module fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             push, pop;

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + (AW+1)'(1);
        if (pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/fifo_out_stage.sv
// rtl/fifo_out_stage.sv - single-entry registered valid/ready output slot for FIFO read-side engines
module fifo_out_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ld_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  m_ready_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o
);
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // The caller only asserts ld_i when the slot is free or draining this cycle.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (ld_i) begin
            valid_d = 1'b1;
            last_d  = last_i;
            data_d  = data_i;
        end else if (valid_q && m_ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign m_valid_o = valid_q;
    assign m_last_o  = last_q;
    assign m_data_o  = data_q;

endmodule

// File: rtl/fifo_pkt_reader.sv
// rtl/fifo_pkt_reader.sv - pops length-prefixed packets from a show-ahead FIFO and streams the payload
module fifo_pkt_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int LEN_W      = HDR_LEN_W,
    parameter int CNT_W      = STAT_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      drop_cnt
);
    rd_state_e        state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [LEN_W-1:0] hdr_len;
    logic             rd_en, ld, last_beat;

    assign hdr_len   = fifo_data[HDR_LEN_LSB +: LEN_W];
    assign last_beat = (remaining_q == LEN_W'(1));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        drop_cnt_d  = drop_cnt_q;
        rd_en       = 1'b0;
        ld          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                rd_en = !fifo_empty;
                if (!fifo_empty) begin
                    if (hdr_len == '0) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    end else begin
                        remaining_d = hdr_len;
                        state_d     = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                ld    = !fifo_empty && (!m_valid || m_ready);
                rd_en = ld;
                if (ld) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (last_beat) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pkt_cnt_d = (m_valid && m_ready && m_last) ? pkt_cnt_q + CNT_W'(1) : pkt_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    fifo_out_stage #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out (
        .clk      (clk),
        .reset_n  (reset_n),
        .ld_i     (ld),
        .data_i   (fifo_data),
        .last_i   (last_beat),
        .m_ready_i(m_ready),
        .m_valid_o(m_valid),
        .m_data_o (m_data),
        .m_last_o (m_last)
    );

    // IDLE would otherwise request a pop from a non-empty FIFO while held in reset.
    assign fifo_rd_en = rd_en && reset_n;
    assign fifo_cs    = fifo_rd_en;
    assign busy       = (state_q != ST_IDLE) || m_valid;
    assign pkt_cnt    = pkt_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
